// File: rtl/uart_pkg.sv
// uart_pkg: types and default sizes shared by the UART transmit and receive controllers
package uart_pkg;
  localparam int DEFAULT_NUM_OF_BYTES = 16;
  localparam int DEFAULT_ADDR_W = 4;
  typedef logic [7:0] uart_byte_t;
  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT_DONE, GAP, DONE} uart_tx_ctrl_state_t;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: loadable down-counter that times the idle gap between bytes
module uart_gap_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic run,
  output logic expired
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  localparam int LOAD = CYCLES > 0 ? CYCLES - 1 : 0;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= W'(LOAD);
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/uart_tx_control.sv
// uart_tx_control: reads a message from RAM and feeds it byte by byte to uart_tx
module uart_tx_control import uart_pkg::*; #(
  parameter int NUM_OF_BYTES = DEFAULT_NUM_OF_BYTES,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              mem_read_enable,
  input  uart_byte_t        mem_read_data,
  output uart_byte_t        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_done,
  output logic              busy,
  output logic              message_sent
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NUM_OF_BYTES - 1);
  uart_tx_ctrl_state_t state, nxt;
  logic [ADDR_W:0] j, j_nxt;
  logic [ADDR_W-1:0] addr_d;
  uart_byte_t data_d;
  logic en_d, start_d, busy_d, sent_d, gap_expired, last;
  assign last = j == LAST;
  uart_gap_timer #(.CYCLES(GAP_CYCLES)) gap_timer (
    .clk(clk),
    .rstn(rstn),
    .load(state == WAIT_DONE && uart_tx_done),
    .run(state == GAP),
    .expired(gap_expired)
  );
  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      j <= '0;
      mem_read_addr <= '0;
      mem_read_enable <= 1'b0;
      uart_tx_data <= '0;
      uart_tx_start <= 1'b0;
      busy <= 1'b0;
      message_sent <= 1'b0;
    end else begin
      state <= nxt;
      j <= j_nxt;
      mem_read_addr <= addr_d;
      mem_read_enable <= en_d;
      uart_tx_data <= data_d;
      uart_tx_start <= start_d;
      busy <= busy_d;
      message_sent <= sent_d;
    end
  always_comb begin
    nxt = state;
    j_nxt = j;
    case (state)
      IDLE: if (start) begin
        nxt = READ;
        j_nxt = '0;
      end
      READ: nxt = LATCH;
      LATCH: nxt = SEND;
      SEND: nxt = WAIT_DONE;
      WAIT_DONE: if (uart_tx_done) begin
        nxt = last ? DONE : GAP_CYCLES > 0 ? GAP : READ;
        j_nxt = last ? j : j + 1'b1;
      end
      GAP: if (gap_expired) nxt = READ;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    en_d = nxt == READ;
    addr_d = nxt == READ ? j_nxt[ADDR_W-1:0] : mem_read_addr;
    data_d = state == LATCH ? mem_read_data : uart_tx_data;
    start_d = nxt == SEND;
    busy_d = nxt != IDLE && nxt != DONE;
    sent_d = nxt == DONE;
  end
endmodule

// File: tb/tb_uart_tx_control.sv
// tb_uart_tx_control: scoreboard bench over default, GAP_CYCLES=3 and single-byte configurations
module tb_uart_tx_control;
  logic clk = 0, rstn = 0;
  logic start [3], en [3], txs [3], done [3], mdone [3], inject [3], busy [3], msent [3];
  logic [3:0] addr [3];
  logic [7:0] rdata [3], txd [3];
  int errs = 0, checks = 0, cyc = 0, act = 0;
  int n_start, n_sent, done_cyc, sent_cyc;
  bit done_pend, sent_pend;
  logic [7:0] last_byte, eb;
  logic [3:0] ea;
  logic [7:0] byte_q [$];
  logic [3:0] addr_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_val(input int k, input logic [3:0] a);
    return k == 0 ? {4'h0, a} : k == 1 ? {4'h4, a} : 8'hA5 ^ {4'h0, a};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : model
    logic [7:0] q;
    int cnt = 0;
    always @(posedge clk) begin
      if (en[k]) q <= ram_val(k, addr[k]);
      if (!rstn) cnt <= 0;
      else if (txs[k]) cnt <= 10;
      else if (cnt > 0) cnt <= cnt - 1;
    end
    assign rdata[k] = q;
    assign mdone[k] = cnt == 1;
    assign done[k] = mdone[k] | inject[k];
  end

  uart_tx_control dut0 (.clk(clk), .rstn(rstn), .start(start[0]), .mem_read_addr(addr[0]),
    .mem_read_enable(en[0]), .mem_read_data(rdata[0]), .uart_tx_data(txd[0]), .uart_tx_start(txs[0]),
    .uart_tx_done(done[0]), .busy(busy[0]), .message_sent(msent[0]));
  uart_tx_control #(.GAP_CYCLES(3)) dut1 (.clk(clk), .rstn(rstn), .start(start[1]), .mem_read_addr(addr[1]),
    .mem_read_enable(en[1]), .mem_read_data(rdata[1]), .uart_tx_data(txd[1]), .uart_tx_start(txs[1]),
    .uart_tx_done(done[1]), .busy(busy[1]), .message_sent(msent[1]));
  uart_tx_control #(.NUM_OF_BYTES(1)) dut2 (.clk(clk), .rstn(rstn), .start(start[2]), .mem_read_addr(addr[2]),
    .mem_read_enable(en[2]), .mem_read_data(rdata[2]), .uart_tx_data(txd[2]), .uart_tx_start(txs[2]),
    .uart_tx_done(done[2]), .busy(busy[2]), .message_sent(msent[2]));

  // Scoreboard monitor for the instance under test; also times read strobes against done and message_sent.
  always @(negedge clk) if (rstn) begin
    if (en[act]) begin
      checks++;
      if (addr_q.size() == 0) begin
        errs++; $display("FAIL rd_addr: unexpected read at addr %0d, none expected", addr[act]);
      end else begin
        ea = addr_q.pop_front();
        if (addr[act] !== ea) begin errs++; $display("FAIL rd_addr: got %0d, expected %0d", addr[act], ea); end
      end
      if (done_pend) begin
        checks++;
        if (cyc - done_cyc != (act == 1 ? 4 : 1)) begin
          errs++; $display("FAIL gap: read %0d cycles after done, expected %0d", cyc - done_cyc, act == 1 ? 4 : 1);
        end
      end
      if (sent_pend) begin
        checks++;
        if (cyc - sent_cyc != 2) begin errs++; $display("FAIL b2b: read %0d cycles after message_sent, expected 2", cyc - sent_cyc); end
      end
      done_pend = 0;
      sent_pend = 0;
    end
    if (txs[act]) begin
      n_start++;
      checks++;
      if (byte_q.size() == 0) begin
        errs++; $display("FAIL tx_byte: unexpected start with data %02h, none expected", txd[act]);
      end else begin
        eb = byte_q.pop_front();
        if (txd[act] !== eb) begin errs++; $display("FAIL tx_byte: got %02h, expected %02h", txd[act], eb); end
      end
      last_byte = txd[act];
    end
    if (mdone[act]) begin
      checks++;
      if (txd[act] !== last_byte) begin errs++; $display("FAIL tx_hold: data %02h at done, expected %02h", txd[act], last_byte); end
      done_cyc = cyc;
      done_pend = 1;
    end
    if (msent[act]) begin
      n_sent++;
      checks++;
      if (!done_pend || cyc - done_cyc != 1) begin
        errs++; $display("FAIL sent_lat: message_sent %0d cycles after done (pending=%0b), expected 1", cyc - done_cyc, done_pend);
      end
      done_pend = 0;
      sent_cyc = cyc;
      sent_pend = 1;
    end
  end

  task automatic clear_sb(input int k);
    act = k;
    n_start = 0;
    n_sent = 0;
    done_pend = 0;
    sent_pend = 0;
    byte_q.delete();
    addr_q.delete();
  endtask

  task automatic push_msg(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(4'(i));
      byte_q.push_back(ram_val(k, 4'(i)));
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk) start[k] = 1;
    @(negedge clk) start[k] = 0;
  endtask

  task automatic wait_sent(input int k, input int budget);
    int t = 0;
    while (!msent[k] && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (!msent[k]) begin errs++; $display("FAIL timeout: message_sent=%0b after %0d cycles, expected 1", msent[k], budget); end
    @(negedge clk);
  endtask

  task automatic test_reset;
    foreach (start[i]) begin start[i] = 0; inject[i] = 0; end
    rstn = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({en[k], txs[k], busy[k], msent[k], addr[k], txd[k]} !== 16'h0) begin
        errs++; $display("FAIL reset: dut%0d outputs %04h, expected 0000", k, {en[k], txs[k], busy[k], msent[k], addr[k], txd[k]});
      end
    end
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_full_message;
    clear_sb(0);
    push_msg(0, 16);
    pulse_start(0);
    wait_sent(0, 2000);
    checks += 4;
    if (n_start != 16) begin errs++; $display("FAIL full_count: %0d starts, expected 16", n_start); end
    if (byte_q.size() + addr_q.size() != 0) begin errs++; $display("FAIL full_left: %0d entries left, expected 0", byte_q.size() + addr_q.size()); end
    if (n_sent != 1) begin errs++; $display("FAIL full_sent: %0d message_sent pulses, expected 1", n_sent); end
    if (busy[0] !== 0) begin errs++; $display("FAIL full_busy: busy=%0b after message, expected 0", busy[0]); end
  endtask

  task automatic test_latency;
    clear_sb(1);
    push_msg(1, 16);
    @(negedge clk) start[1] = 1;
    @(negedge clk) start[1] = 0;
    checks += 5;
    if ({en[1], busy[1], addr[1]} !== 6'b110000) begin
      errs++; $display("FAIL lat_c1: en/busy/addr=%0b/%0b/%0d, expected 1/1/0", en[1], busy[1], addr[1]);
    end
    @(negedge clk);
    if ({en[1], txs[1]} !== 2'b00) begin errs++; $display("FAIL lat_c2: en/start=%0b/%0b, expected 0/0", en[1], txs[1]); end
    @(negedge clk);
    if (txs[1] !== 1) begin errs++; $display("FAIL lat_c3: uart_tx_start=%0b, expected 1", txs[1]); end
    if (txd[1] !== 8'h40) begin errs++; $display("FAIL lat_data: data=%02h, expected 40", txd[1]); end
    @(negedge clk);
    if (txs[1] !== 0) begin errs++; $display("FAIL lat_pulse: uart_tx_start=%0b in cycle 4, expected 0", txs[1]); end
    wait_sent(1, 4000);
  endtask

  task automatic test_gap;
    clear_sb(1);
    push_msg(1, 16);
    pulse_start(1);
    wait_sent(1, 4000);
    checks += 2;
    if (n_start != 16) begin errs++; $display("FAIL gap_count: %0d starts, expected 16", n_start); end
    if (n_sent != 1) begin errs++; $display("FAIL gap_sent: %0d message_sent pulses, expected 1", n_sent); end
  endtask

  task automatic test_spurious;
    int r = 0, t = 0;
    clear_sb(0);
    push_msg(0, 16);
    pulse_start(0);
    while (r < 3 && t < 1000) begin @(negedge clk); t++; if (en[0]) r++; end
    @(negedge clk);
    inject[0] = 1;
    start[0] = 1;
    @(negedge clk);
    inject[0] = 0;
    start[0] = 0;
    wait_sent(0, 3000);
    repeat (5) @(negedge clk);
    checks += 3;
    if (n_start != 16) begin errs++; $display("FAIL spur_count: %0d starts, expected 16", n_start); end
    if (byte_q.size() + addr_q.size() != 0) begin errs++; $display("FAIL spur_left: %0d entries left, expected 0", byte_q.size() + addr_q.size()); end
    if (n_sent != 1) begin errs++; $display("FAIL spur_sent: %0d message_sent pulses, expected 1", n_sent); end
  endtask

  task automatic test_reset_mid;
    int s = 0, t = 0;
    clear_sb(0);
    push_msg(0, 16);
    pulse_start(0);
    while (s < 6 && t < 2000) begin @(negedge clk); t++; if (txs[0]) s++; end
    rstn = 0;
    @(negedge clk);
    checks += 2;
    if ({en[0], txs[0], busy[0], msent[0], addr[0], txd[0]} !== 16'h0) begin
      errs++; $display("FAIL rst_mid: outputs %04h, expected 0000", {en[0], txs[0], busy[0], msent[0], addr[0], txd[0]});
    end
    rstn = 1;
    clear_sb(0);
    repeat (20) @(negedge clk);
    if (n_sent != 0 || n_start != 0) begin errs++; $display("FAIL rst_idle: %0d sent %0d starts after reset, expected 0 0", n_sent, n_start); end
    push_msg(0, 16);
    pulse_start(0);
    wait_sent(0, 2000);
    checks += 2;
    if (n_start != 16) begin errs++; $display("FAIL rst_count: %0d starts, expected 16", n_start); end
    if (n_sent != 1) begin errs++; $display("FAIL rst_sent: %0d message_sent pulses, expected 1", n_sent); end
  endtask

  task automatic test_back_to_back;
    int s = 0, t = 0;
    clear_sb(2);
    for (int m = 0; m < 4; m++) push_msg(2, 1);
    @(negedge clk) start[2] = 1;
    while (s < 4 && t < 1000) begin @(negedge clk); t++; if (msent[2]) s++; end
    start[2] = 0;
    repeat (5) @(negedge clk);
    checks += 3;
    if (s != 4 || n_sent != 4) begin errs++; $display("FAIL b2b_sent: %0d/%0d messages, expected 4", s, n_sent); end
    if (n_start != 4) begin errs++; $display("FAIL b2b_count: %0d starts, expected 4", n_start); end
    if (byte_q.size() + addr_q.size() != 0) begin errs++; $display("FAIL b2b_left: %0d entries left, expected 0", byte_q.size() + addr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_message();
    test_latency();
    test_gap();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_control.md
# uart_tx_control

Sequencing controller for the UART transmit path: on a `start` request it reads `NUM_OF_BYTES` bytes from the message RAM, starting at address 0. It hands each byte to the uart_tx FSM with a one-cycle `uart_tx_start` pulse and waits for `uart_tx_done` before moving to the next byte. An optional idle gap is inserted between bytes. Completion is reported with a `message_sent` pulse. It is the transmit-side counterpart of the receive controller and shares the same RAM and uart_tx/uart_rx handshake conventions.

## Interface
- `NUM_OF_BYTES`, default 16: bytes per message, range 1..2**ADDR_W.
- `ADDR_W`, default 4: RAM address width.
- `GAP_CYCLES`, default 0: idle cycles inserted between `uart_tx_done` and the next RAM read; 0 disables the gap.
- `clk`  in  1: clock; all logic on posedge.
- `rstn`  in  1: reset, synchronous, active-low.
- `start`  in  1: level-sampled request to send one message.
- `mem_read_addr`  out  ADDR_W: RAM read address.
- `mem_read_enable`  out  1: RAM read strobe.
- `mem_read_data`  in  8: RAM data, valid the cycle after `mem_read_enable`.
- `uart_tx_data`  out  8: byte to transmit; held stable from the start pulse until done.
- `uart_tx_start`  out  1: one-cycle pulse launching uart_tx.
- `uart_tx_done`  in  1: pulse from uart_tx when the byte has been shifted out.
- `busy`  out  1: high from the cycle after `start` is accepted until `message_sent`.
- `message_sent`  out  1: one-cycle pulse after the last byte completes.

## Operation
- All outputs are registered from a single always_ff state machine.
- Reset values: all outputs 0, byte index j=0, gap counter 0, state IDLE.
- States and transitions:
  - IDLE: when `start`=1, set j=0 and go to READ. Otherwise stay.
  - READ: drive `mem_read_enable`=1 and `mem_read_addr`=j, then go to LATCH.
  - LATCH: capture `mem_read_data` into `uart_tx_data`, then go to SEND.
  - SEND: drive `uart_tx_start`=1 for exactly one cycle, then go to WAIT_DONE.
  - WAIT_DONE: wait for `uart_tx_done`=1.
    - On done with j==NUM_OF_BYTES-1, go to DONE.
    - On done otherwise, increment j and go to GAP if GAP_CYCLES>0, else go to READ.
  - GAP: count GAP_CYCLES cycles, then go to READ.
  - DONE: `message_sent`=1 and `busy`=0 for one cycle, then go to IDLE.
- `mem_read_enable` and `uart_tx_start` are 0 in every state except READ and SEND respectively.
- `uart_tx_data` keeps its last value in all other states.
- j is ADDR_W+1 bits wide and is compared against NUM_OF_BYTES-1. j never wraps, so `mem_read_addr` is always ≤ NUM_OF_BYTES-1.
- Boundary conditions:
  - `start` while busy: ignored, not queued.
  - `start` held high through DONE: a new message begins in the cycle after the return to IDLE, i.e. back-to-back messages.
  - `uart_tx_done` in any state other than WAIT_DONE: ignored.
  - `uart_tx_done` held high for several cycles: counts once, because the state leaves WAIT_DONE on the first cycle.
  - Reset mid-message: at the next edge, all outputs go to their reset values, including a `uart_tx_start` pulse in progress. No partial-message completion is reported.

## Timing
- `start` is sampled high at edge E0.
  - Cycle 1 after E0: `mem_read_enable`=1, addr=0, `busy`=1.
  - Cycle 2: RAM data is sampled.
  - Cycle 3: `uart_tx_start`=1 with the byte already on `uart_tx_data`.
- `uart_tx_done` is sampled at edge Ed:
  - Not the last byte: the next `mem_read_enable` occurs GAP_CYCLES+1 cycles after Ed.
  - Last byte: `message_sent` in cycle Ed+1.
- Per-byte overhead excluding uart_tx time: 3 + GAP_CYCLES cycles.

## Structure
- Shared package `uart_pkg`:
  - state enum typedef `uart_tx_ctrl_state_t` (IDLE, READ, LATCH, SEND, WAIT_DONE, GAP, DONE);
  - byte type `uart_byte_t` (logic [7:0]);
  - default constants NUM_OF_BYTES=16 and ADDR_W=4, shared with the receive controller.
- One sub-module, `uart_gap_timer`: a loadable down-counter with a `load` input and an `expired` output, used in the GAP state.
- Everything else stays in the top FSM.

## Test plan
- Send a full message: RAM holds 0x00..0x0F, uart_tx model returns done 10 cycles after each start, `start` pulsed once.
  - Expect exactly 16 start pulses carrying bytes 0x00..0x0F in order.
  - Expect addresses 0..15.
  - Expect a single `message_sent` pulse one cycle after the 16th done; `busy` then drops.
- Check the first-byte latency: `start` at edge E0.
  - Expect `mem_read_enable` in cycle 1, `uart_tx_start` in cycle 3, and `uart_tx_data`=RAM[0] stable until done.
- GAP_CYCLES=3: expect each next `mem_read_enable` exactly 4 cycles after each non-final done.
- `start` re-pulsed mid-message, plus a spurious `uart_tx_done` during LATCH: expect the byte count to stay 16, the order to be unchanged, and only one `message_sent`.
- Assert `rstn`=0 in the cycle `uart_tx_start`=1 during byte 5, then restart.
  - Expect all outputs 0 at the next edge.
  - Expect the new message to begin at address 0.
- NUM_OF_BYTES=1 with `start` held high: expect back-to-back messages, each reading address 0, with `message_sent` followed by `mem_read_enable` two cycles later.
